if_pc_predictor: RTL and testbench

- IF-stage next-PC generator. It produces the PC_IF/NPC_IF pair that the IF/ID PC segment register captures.
- Holds the fetch PC register plus a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves predictions against EX-stage outcomes. On a mispredict it raises a redirect to the hazard unit, which flushes the younger stages.

---
 rtl/if_pc_predictor.sv | 169 ++++++++++++++++
 tb/tb_if_pc_predictor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_predictor.sv
// ---------------------------------------------------------------------------
// if_pc_predictor
//
// IF-stage next-PC generator. It holds the fetch PC register and a
// direct-mapped branch target buffer (BTB). Each BTB entry has a valid bit,
// a tag, a target and a 2-bit saturating direction counter. Predictions are
// checked against the resolved outcome of the instruction in EX. A wrong
// prediction raises redirect, which the hazard unit uses to flush ID and EX.
//
// Parameters:
//   BTB_ENTRIES  number of BTB entries (power of 2, >= 2)
//   RESET_PC     fetch address loaded on reset
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bubbleF    in   hold the PC register (IF stall)
//   ex_valid   in   EX slot holds a real instruction
//   br_EX      in   EX instruction is a branch / jal / jalr
//   taken_EX   in   resolved direction (only meaningful when br_EX=1)
//   target_EX  in   resolved branch/jump target
//   PC_EX      in   PC of the EX instruction
//   NPC_EX     in   predicted next PC that travelled with the EX instruction
//   PC_IF      out  current fetch address
//   NPC_IF     out  predicted next fetch address
//   redirect   out  mispredict detected in EX
//
// Optional feature (macro IF_PC_PREDICTOR_STATS_EN):
//   br_count       out  number of resolved branches (saturating)
//   mispred_count  out  number of redirects (saturating)
// ---------------------------------------------------------------------------
module if_pc_predictor #(
   parameter int          BTB_ENTRIES = 8,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bubbleF,
   input  logic        ex_valid,
   input  logic        br_EX,
   input  logic        taken_EX,
   input  logic [31:0] target_EX,
   input  logic [31:0] PC_EX,
   input  logic [31:0] NPC_EX,
   output logic [31:0] PC_IF,
   output logic [31:0] NPC_IF,
   output logic        redirect
`ifdef IF_PC_PREDICTOR_STATS_EN
   ,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
`endif
);

   localparam int IDX  = $clog2(BTB_ENTRIES);
   localparam int TAGW = 32 - IDX - 2;

   // BTB storage
   logic [BTB_ENTRIES-1:0] r_valid;
   logic [1:0]             r_cnt    [BTB_ENTRIES];
   logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
   logic [31:0]            r_target [BTB_ENTRIES];

   logic [31:0]     r_pc;

   logic [IDX-1:0]  w_ifIdx;
   logic [TAGW-1:0] w_ifTag;
   logic            w_ifHit;
   logic [31:0]     w_pcPlus4;

   logic [IDX-1:0]  w_exIdx;
   logic [TAGW-1:0] w_exTag;
   logic            w_exHit;
   logic [31:0]     w_exPlus4;
   logic [31:0]     w_actual;
   logic            w_redirect;
   logic            w_brResolve;

   // Fetch-side lookup: the low two PC bits never take part in indexing
   assign w_ifIdx   = r_pc[IDX+1:2];
   assign w_ifTag   = r_pc[31:IDX+2];
   assign w_ifHit   = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);
   assign w_pcPlus4 = r_pc + 32'd4;

   assign PC_IF  = r_pc;
   assign NPC_IF = (w_ifHit && r_cnt[w_ifIdx][1]) ? r_target[w_ifIdx] : w_pcPlus4;

   // EX-side resolution. Non-branches resolve to PC+4, so a stale BTB hit
   // on a non-branch is caught by the same comparison. The reset gate keeps
   // redirect low while rst_n is asserted regardless of ex_valid.
   assign w_exIdx     = PC_EX[IDX+1:2];
   assign w_exTag     = PC_EX[31:IDX+2];
   assign w_exHit     = r_valid[w_exIdx] && (r_tag[w_exIdx] == w_exTag);
   assign w_exPlus4   = PC_EX + 32'd4;
   assign w_actual    = (br_EX && taken_EX) ? target_EX : w_exPlus4;
   assign w_redirect  = rst_n && ex_valid && (w_actual != NPC_EX);
   assign w_brResolve = ex_valid && br_EX;

   assign redirect = w_redirect;

   // PC register: a redirect wins over a stall, a stall holds the PC,
   // otherwise follow the prediction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (w_redirect) begin
         r_pc <= w_actual;
      end else if (!bubbleF) begin
         r_pc <= NPC_IF;
      end
   end

   // BTB training from the EX outcome. The lookup above reads the arrays
   // before this edge, so a same-index update only becomes visible on the
   // following cycle. Taken misses allocate weakly-taken; not-taken misses
   // leave the table alone; hits on non-branches are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            r_cnt[i]    <= 2'b01;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
         end
      end else if (w_brResolve) begin
         if (w_exHit) begin
            if (taken_EX) begin
               if (r_cnt[w_exIdx] != 2'b11) begin
                  r_cnt[w_exIdx] <= r_cnt[w_exIdx] + 2'd1;
               end
               r_target[w_exIdx] <= target_EX;
            end else if (r_cnt[w_exIdx] != 2'b00) begin
               r_cnt[w_exIdx] <= r_cnt[w_exIdx] - 2'd1;
            end
         end else if (taken_EX) begin
            r_valid[w_exIdx]  <= 1'b1;
            r_tag[w_exIdx]    <= w_exTag;
            r_target[w_exIdx] <= target_EX;
            r_cnt[w_exIdx]    <= 2'b10;
         end
      end else if (ex_valid && w_exHit) begin
         r_valid[w_exIdx] <= 1'b0;
      end
   end

`ifdef IF_PC_PREDICTOR_STATS_EN
   logic [31:0] r_brCount;
   logic [31:0] r_mispredCount;

   // Saturating event counters for resolved branches and redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_brCount      <= '0;
         r_mispredCount <= '0;
      end else begin
         if (w_brResolve && (r_brCount != 32'hFFFF_FFFF)) begin
            r_brCount <= r_brCount + 32'd1;
         end
         if (w_redirect && (r_mispredCount != 32'hFFFF_FFFF)) begin
            r_mispredCount <= r_mispredCount + 32'd1;
         end
      end
   end

   assign br_count      = r_brCount;
   assign mispred_count = r_mispredCount;
`endif

endmodule

// File: tb/tb_if_pc_predictor.sv
// ---------------------------------------------------------------------------
// tb_if_pc_predictor
//
// Self-checking bench for if_pc_predictor. A behavioural model of the fetch
// PC and BTB (plain arrays and arithmetic) predicts PC_IF, NPC_IF and
// redirect every cycle. Directed sequences cover the reset, taken/not-taken
// training, stall/redirect priority and PC wrap cases; a randomized phase
// follows. Define IF_PC_PREDICTOR_STATS_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_if_pc_predictor;

   localparam int          N        = 8;
   localparam int          SH       = 5;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        bubbleF;
   logic        ex_valid;
   logic        br_EX;
   logic        taken_EX;
   logic [31:0] target_EX;
   logic [31:0] PC_EX;
   logic [31:0] NPC_EX;
   logic [31:0] PC_IF;
   logic [31:0] NPC_IF;
   logic        redirect;
`ifdef IF_PC_PREDICTOR_STATS_EN
   logic [31:0] br_count;
   logic [31:0] mispred_count;
`endif

   if_pc_predictor #(.BTB_ENTRIES(N), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bubbleF(bubbleF),
      .ex_valid(ex_valid),
      .br_EX(br_EX),
      .taken_EX(taken_EX),
      .target_EX(target_EX),
      .PC_EX(PC_EX),
      .NPC_EX(NPC_EX),
      .PC_IF(PC_IF),
      .NPC_IF(NPC_IF),
      .redirect(redirect)
`ifdef IF_PC_PREDICTOR_STATS_EN
      ,
      .br_count(br_count),
      .mispred_count(mispred_count)
`endif
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int compCount = 0;
   int mismCount = 0;

   // Reference model state
   logic [31:0] mPc;
   bit          mValid  [N];
   logic [31:0] mTag    [N];
   logic [31:0] mTarget [N];
   int          mCnt    [N];
   longint      mBr;
   longint      mMis;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compCount++;
      if (observed !== expected) begin
         mismCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic bit hitOf(input logic [31:0] pc);
      return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == (pc >> SH));
   endfunction

   function automatic logic [31:0] predict(input logic [31:0] pc);
      if (hitOf(pc) && mCnt[idxOf(pc)] >= 2) return mTarget[idxOf(pc)];
      return pc + 32'd4;
   endfunction

   function automatic void modelReset();
      mPc = RESET_PC;
      for (int i = 0; i < N; i++) begin
         mValid[i]  = 1'b0;
         mTag[i]    = '0;
         mTarget[i] = '0;
         mCnt[i]    = 1;
      end
      mBr  = 0;
      mMis = 0;
   endfunction

   // Drive one cycle of inputs, compare against the model, clock, advance model
   task automatic applyStimulus(input logic bub, input logic exv, input logic br,
                                input logic tk, input logic [31:0] tgt,
                                input logic [31:0] pcx, input logic [31:0] npcx);
      logic [31:0] expNpc;
      logic [31:0] expAct;
      bit          expRed;
      int          ix;
      bubbleF   = bub;
      ex_valid  = exv;
      br_EX     = br;
      taken_EX  = tk;
      target_EX = tgt;
      PC_EX     = pcx;
      NPC_EX    = npcx;
      #1;
      expNpc = predict(mPc);
      expAct = (br && tk) ? tgt : pcx + 32'd4;
      expRed = exv && (expAct != npcx);
      checkOutput("PC_IF", PC_IF, mPc);
      checkOutput("NPC_IF", NPC_IF, expNpc);
      checkOutput("redirect", {31'b0, redirect}, {31'b0, expRed});
`ifdef IF_PC_PREDICTOR_STATS_EN
      checkOutput("br_count", br_count, 32'(mBr));
      checkOutput("mispred_count", mispred_count, 32'(mMis));
`endif
      @(posedge clk);
      if (expRed) mPc = expAct;
      else if (!bub) mPc = expNpc;
      ix = idxOf(pcx);
      if (exv && br) begin
         if (hitOf(pcx)) begin
            if (tk) begin
               mCnt[ix]    = (mCnt[ix] + 1 > 3) ? 3 : mCnt[ix] + 1;
               mTarget[ix] = tgt;
            end else begin
               mCnt[ix] = (mCnt[ix] - 1 < 0) ? 0 : mCnt[ix] - 1;
            end
         end else if (tk) begin
            mValid[ix]  = 1'b1;
            mTag[ix]    = pcx >> SH;
            mTarget[ix] = tgt;
            mCnt[ix]    = 2;
         end
         if (mBr < 64'hFFFF_FFFF) mBr++;
      end else if (exv && hitOf(pcx)) begin
         mValid[ix] = 1'b0;
      end
      if (expRed && mMis < 64'hFFFF_FFFF) mMis++;
      #1;
   endtask

   // Assert reset between edges with a mispredicting EX slot present
   task automatic doReset();
      ex_valid  = 1'b1;
      br_EX     = 1'b1;
      taken_EX  = 1'b1;
      target_EX = 32'h0000_0ABC;
      PC_EX     = 32'h0000_0100;
      NPC_EX    = 32'h0000_0104;
      bubbleF   = 1'b0;
      rst_n     = 1'b0;
      #1;
      modelReset();
      checkOutput("rstPc", PC_IF, RESET_PC);
      checkOutput("rstRedirect", {31'b0, redirect}, 32'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      ex_valid = 1'b0;
      br_EX    = 1'b0;
      #1;
   endtask

   initial begin
      logic [31:0] pcx;
      logic [31:0] tgt;
      logic [31:0] npcx;
      int          sel;
      rst_n     = 1'b0;
      bubbleF   = 1'b0;
      ex_valid  = 1'b0;
      br_EX     = 1'b0;
      taken_EX  = 1'b0;
      target_EX = '0;
      PC_EX     = '0;
      NPC_EX    = '0;
      doReset();

      // Sequential fetch from reset
      for (int i = 0; i < 3; i++) begin
         checkOutput("seqPc", PC_IF, 32'(4 * i));
         applyStimulus(0, 0, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 13; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("preRstPc", PC_IF, 32'h40);
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Taken branch at 0x10 allocates and redirects
      applyStimulus(0, 1, 1, 1, 32'h80, 32'h10, 32'h14);
      checkOutput("takenPc", PC_IF, 32'h80);
      applyStimulus(0, 1, 0, 0, 0, 32'hC, 32'h0);
      checkOutput("predTaken", NPC_IF, 32'h80);

      // Two not-taken resolutions walk the counter down to 0
      applyStimulus(0, 1, 1, 0, 32'h80, 32'h10, 32'h80);
      checkOutput("notTakenPc", PC_IF, 32'h14);
      applyStimulus(0, 1, 1, 0, 32'h80, 32'h10, 32'h14);
      applyStimulus(0, 1, 0, 0, 0, 32'hC, 32'h0);
      checkOutput("predNotTaken", NPC_IF, 32'h14);

      // Redirect overrides a stall, then a plain stall holds the PC
      applyStimulus(1, 1, 0, 0, 0, 32'h1FC, 32'h0);
      checkOutput("stallRedirPc", PC_IF, 32'h200);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 0);
         checkOutput("stallHoldPc", PC_IF, 32'h200);
      end

      // PC+4 wraps at the top of the address space
      applyStimulus(0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);
      checkOutput("wrapPc", PC_IF, 32'hFFFF_FFFC);
      checkOutput("wrapNpc", NPC_IF, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

`ifdef IF_PC_PREDICTOR_STATS_EN
      doReset();
      applyStimulus(0, 1, 1, 1, 32'h80, 32'h10, 32'h14);
      applyStimulus(0, 1, 1, 0, 32'h40, 32'h20, 32'h24);
      checkOutput("statBr", br_count, 32'd2);
      checkOutput("statMis", mispred_count, 32'd1);
`endif

      // Randomized phase against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) doReset();
         sel = int'($urandom_range(0, 3));
         pcx = (($urandom_range(0, 1) != 0) ? 32'h100 : 32'h1000)
               + 32'($urandom_range(0, 15) * 4);
         tgt = {$urandom_range(0, 255), 2'b00} & 32'h3FC;
         case (sel)
            0: npcx = pcx + 32'd4;
            1: npcx = tgt;
            2: npcx = predict(pcx);
            default: npcx = $urandom;
         endcase
         applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                       tgt, pcx, npcx);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, mismCount);
      $finish;
   end

endmodule
